// File: rtl/leaf_fanin_arbiter.sv
// Merges NUM_SRC leaf valid/ready streams into one registered upstream stream
// using round-robin arbitration, tagging each word with its source index.
module leaf_fanin_arbiter #(
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SRC_W   = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        in_valid,
    input  logic [NUM_SRC*DATA_W-1:0] in_data,
    output logic [NUM_SRC-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                can_load;
    logic                gnt_found;
    logic [SRC_W-1:0]    gnt_src;
    logic [NUM_SRC-1:0]  gnt_oh;
    logic [DATA_W-1:0]   gnt_data;
    int unsigned         idx;

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign xfer_cnt  = cnt_q;
    assign in_ready  = gnt_oh;
    assign can_load  = !out_valid || out_ready;

    // Scan from the source after the last grant, wrapping modulo NUM_SRC.
    always_comb begin
        gnt_oh    = '0;
        gnt_src   = '0;
        gnt_found = 1'b0;
        idx       = 0;
        if (can_load) begin
            for (int unsigned k = 1; k <= NUM_SRC; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!gnt_found && in_valid[IDX_W'(idx)]) begin
                    gnt_found              = 1'b1;
                    gnt_src                = SRC_W'(idx);
                    gnt_oh[IDX_W'(idx)]    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gnt_oh[i]) begin
                gnt_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (gnt_found) begin
            state_d = FULL;
            data_d  = gnt_data;
            src_d   = gnt_src;
            ptr_d   = gnt_src;
        end else if (out_valid && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= SRC_W'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_leaf_fanin_arbiter.sv
// Scoreboard bench for leaf_fanin_arbiter: a round-robin reference model pushes
// expected words, a monitor pops and compares them as the DUT emits them.
module tb_leaf_fanin_arbiter;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int SW = 3;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_src;
    logic              out_ready;
    logic [CW-1:0]     xfer_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          src;
        logic [DW-1:0] data;
    } item_t;

    item_t        exp_q[$];
    bit           occupied;
    int           ptr;
    logic [N-1:0] mdl_hs;
    int           mon_cnt;

    leaf_fanin_arbiter #(
        .NUM_SRC(N),
        .DATA_W (DW),
        .SRC_W  (SW),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one step per cycle, just before the rising edge.
    initial begin : model
        int           g;
        int           s;
        logic [N-1:0] er;
        item_t        it;
        occupied = 1'b0;
        ptr      = N - 1;
        mdl_hs   = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                occupied = 1'b0;
                ptr      = N - 1;
                exp_q.delete();
                mdl_hs   = '0;
            end else begin
                g  = -1;
                er = '0;
                if (!occupied || out_ready) begin
                    for (int k = 1; k <= N; k++) begin
                        s = (ptr + k) % N;
                        if (((in_valid >> s) & N'(1)) != '0) begin
                            g = s;
                            break;
                        end
                    end
                end
                if (g >= 0) er = N'(1) << g;
                check("in_ready", in_ready, er);
                check("out_valid", out_valid, occupied);
                if (g >= 0) begin
                    it.src  = g;
                    it.data = DW'(in_data >> (g * DW));
                    exp_q.push_back(it);
                    occupied = 1'b1;
                    ptr      = g;
                end else if (occupied && out_ready) begin
                    occupied = 1'b0;
                end
                mdl_hs = er;
            end
        end
    end

    initial begin : monitor
        mon_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_xfer_cnt", xfer_cnt, 0);
                mon_cnt = 0;
            end else begin
                check("xfer_cnt", xfer_cnt, mon_cnt);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL out_word at %0t: actual=src%0d/%0h expected=no word", $time, out_src, out_data);
                    end else begin
                        check("out_src", out_src, exp_q[0].src);
                        check("out_data", out_data, exp_q[0].data);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            mon_cnt = (mon_cnt + 1) % (1 << CW);
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (10) @(negedge clk);

        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(16'h1000 + i);
        in_valid = '1;
        repeat (10) @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);

        in_data[2*DW +: DW] = 16'h00AA;
        in_valid = N'(1) << 2;
        @(negedge clk);
        in_valid  = N'(3);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);

        in_valid = N'(1) << 3;
        @(negedge clk);
        in_valid = (N'(1) << 3) | (N'(1) << 1);
        repeat (6) @(negedge clk);
        in_valid = '0;
        repeat (2) @(negedge clk);

        // Hold a word under backpressure, then reset in the middle of the cycle.
        in_valid  = '1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        in_valid = '0;
        repeat (3) @(negedge clk);

        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !mdl_hs[i])) begin
                    in_valid[i]         = ($urandom_range(0, 99) < 50);
                    in_data[i*DW +: DW] = DW'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
